// File: rtl/stage3.sv
// rtl/stage3.sv - Execute stage: ALU, Z/N flags, J/BRZ/BRN resolution, squash and EX/MEM buffer.
module stage3 #(
    parameter int WIDTH        = 32,
    parameter int RADDR        = 6,
    parameter int SQUASH_SLOTS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [RADDR-1:0] in_rd,
    input  logic [WIDTH-1:0] in_rd1,
    input  logic [WIDTH-1:0] in_rd2,
    input  logic [WIDTH-1:0] in_PC,
    input  logic             in_brz,
    input  logic             in_brn,
    input  logic             in_j,
    input  logic             in_regw,
    input  logic             in_wai,
    input  logic             in_memw,
    input  logic             in_memr,
    input  logic             in_alusrc,
    input  logic [2:0]       in_aluop,
    input  logic             in_hold,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_alu,
    output logic [WIDTH-1:0] out_rd2,
    output logic [RADDR-1:0] out_rd,
    output logic [WIDTH-1:0] out_PC,
    output logic             out_regw,
    output logic             out_wai,
    output logic             out_memw,
    output logic             out_memr,
    output logic             out_take,
    output logic [WIDTH-1:0] out_target,
    output logic             out_z,
    output logic             out_n,
    output logic             out_squashing
);

    localparam logic [1:0] SLOTS = 2'(SQUASH_SLOTS);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] rd2_q, rd2_d;
    logic [RADDR-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             regw_q, regw_d;
    logic             wai_q, wai_d;
    logic             memw_q, memw_d;
    logic             memr_q, memr_d;
    logic             take_q, take_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic [1:0]       sq_q, sq_d;

    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic             eff_valid;
    logic             take;

    assign op_b      = in_alusrc ? in_imm : in_rd2;
    assign eff_valid = in_valid & (sq_q == 2'd0);
    // Branch conditions see the flags as they stood before this instruction.
    assign take      = eff_valid & (in_j | (in_brz & z_q) | (in_brn & n_q));

    always_comb begin
        alu_res = '0;
        case (in_aluop)
            3'b000:  alu_res = in_rd1 + op_b;
            3'b001:  alu_res = in_rd1 - op_b;
            3'b010:  alu_res = {WIDTH{1'b0}} - in_rd1;
            3'b011:  alu_res = op_b;
            3'b100:  alu_res = in_rd1;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        valid_d  = valid_q;
        alu_d    = alu_q;
        rd2_d    = rd2_q;
        rd_d     = rd_q;
        pc_d     = pc_q;
        regw_d   = regw_q;
        wai_d    = wai_q;
        memw_d   = memw_q;
        memr_d   = memr_q;
        take_d   = 1'b0;
        target_d = target_q;
        z_d      = z_q;
        n_d      = n_q;
        sq_d     = sq_q;
        if (!in_hold) begin
            valid_d = eff_valid;
            alu_d   = alu_res;
            rd2_d   = in_rd2;
            rd_d    = in_rd;
            pc_d    = in_PC;
            regw_d  = eff_valid & in_regw;
            wai_d   = in_wai;
            memw_d  = eff_valid & in_memw;
            memr_d  = eff_valid & in_memr;
            if (eff_valid && in_regw && !in_memr) begin
                z_d = (alu_res == '0);
                n_d = alu_res[WIDTH-1];
            end
            if (take) begin
                take_d   = 1'b1;
                target_d = in_rd1;
                sq_d     = SLOTS;
            end else if (sq_q != 2'd0 && in_valid) begin
                sq_d = sq_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            alu_q    <= '0;
            rd2_q    <= '0;
            rd_q     <= '0;
            pc_q     <= '0;
            regw_q   <= 1'b0;
            wai_q    <= 1'b0;
            memw_q   <= 1'b0;
            memr_q   <= 1'b0;
            take_q   <= 1'b0;
            target_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            sq_q     <= 2'd0;
        end else begin
            valid_q  <= valid_d;
            alu_q    <= alu_d;
            rd2_q    <= rd2_d;
            rd_q     <= rd_d;
            pc_q     <= pc_d;
            regw_q   <= regw_d;
            wai_q    <= wai_d;
            memw_q   <= memw_d;
            memr_q   <= memr_d;
            take_q   <= take_d;
            target_q <= target_d;
            z_q      <= z_d;
            n_q      <= n_d;
            sq_q     <= sq_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_alu       = alu_q;
    assign out_rd2       = rd2_q;
    assign out_rd        = rd_q;
    assign out_PC        = pc_q;
    assign out_regw      = regw_q;
    assign out_wai       = wai_q;
    assign out_memw      = memw_q;
    assign out_memr      = memr_q;
    assign out_take      = take_q;
    assign out_target    = target_q;
    assign out_z         = z_q;
    assign out_n         = n_q;
    assign out_squashing = (sq_q != 2'd0);

endmodule

// File: tb/tb_stage3.sv
// tb/tb_stage3.sv - Scoreboard bench for stage3 with directed and randomized ID/EX stimulus.
module tb_stage3;

    localparam int SLOTS = 2;

    typedef struct {
        logic        valid, hold;
        logic [31:0] imm, rd1, rd2, pc;
        logic [5:0]  rd;
        logic        brz, brn, j, regw, wai, memw, memr, alusrc;
        logic [2:0]  aluop;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [31:0] alu, rd2;
        logic [5:0]  rd;
        logic [31:0] pc;
        logic        regw, wai, memw, memr, take;
        logic [31:0] target;
        logic        z, n, sq;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_hold = 1'b0;
    logic [31:0] in_imm = '0, in_rd1 = '0, in_rd2 = '0, in_PC = '0;
    logic [5:0]  in_rd = '0;
    logic        in_brz = 1'b0, in_brn = 1'b0, in_j = 1'b0, in_regw = 1'b0;
    logic        in_wai = 1'b0, in_memw = 1'b0, in_memr = 1'b0, in_alusrc = 1'b0;
    logic [2:0]  in_aluop = '0;
    logic        out_valid, out_regw, out_wai, out_memw, out_memr, out_take;
    logic        out_z, out_n, out_squashing;
    logic [31:0] out_alu, out_rd2, out_PC, out_target;
    logic [5:0]  out_rd;

    stage3 #(.WIDTH(32), .RADDR(6), .SQUASH_SLOTS(SLOTS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_imm(in_imm), .in_rd(in_rd),
        .in_rd1(in_rd1), .in_rd2(in_rd2), .in_PC(in_PC), .in_brz(in_brz), .in_brn(in_brn),
        .in_j(in_j), .in_regw(in_regw), .in_wai(in_wai), .in_memw(in_memw),
        .in_memr(in_memr), .in_alusrc(in_alusrc), .in_aluop(in_aluop), .in_hold(in_hold),
        .out_valid(out_valid), .out_alu(out_alu), .out_rd2(out_rd2), .out_rd(out_rd),
        .out_PC(out_PC), .out_regw(out_regw), .out_wai(out_wai), .out_memw(out_memw),
        .out_memr(out_memr), .out_take(out_take), .out_target(out_target),
        .out_z(out_z), .out_n(out_n), .out_squashing(out_squashing)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    out_t mo;
    int   m_sq;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '{valid: 1'b0, hold: 1'b0, imm: 32'd0, rd1: 32'd0, rd2: 32'd0, pc: 32'd0,
              rd: 6'd0, brz: 1'b0, brn: 1'b0, j: 1'b0, regw: 1'b0, wai: 1'b0,
              memw: 1'b0, memr: 1'b0, alusrc: 1'b0, aluop: 3'd0};
        return s;
    endfunction

    function automatic stim_t alu_op(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic use_imm);
        stim_t s;
        s        = nop();
        s.valid  = 1'b1;
        s.aluop  = op;
        s.rd1    = a;
        s.regw   = 1'b1;
        s.alusrc = use_imm;
        if (use_imm) s.imm = b; else s.rd2 = b;
        s.rd = 6'($urandom_range(1, 63));
        s.pc = $urandom & 32'hFFFF_FFFC;
        return s;
    endfunction

    function automatic stim_t ctl(input logic brz, input logic brn, input logic j,
                                  input logic [31:0] target);
        stim_t s;
        s       = nop();
        s.valid = 1'b1;
        s.brz   = brz;
        s.brn   = brn;
        s.j     = j;
        s.rd1   = target;
        s.pc    = $urandom & 32'hFFFF_FFFC;
        return s;
    endfunction

    // Reference: the architectural effect of one clock edge on the EX/MEM slot.
    task automatic model_step(input stim_t s);
        logic [31:0] b, res;
        logic        live, taken;
        if (s.hold) begin
            mo.take = 1'b0;
            return;
        end
        live = s.valid && (m_sq == 0);
        b    = s.alusrc ? s.imm : s.rd2;
        case (int'(s.aluop))
            0:       res = s.rd1 + b;
            1:       res = s.rd1 - b;
            2:       res = 32'd0 - s.rd1;
            3:       res = b;
            4:       res = s.rd1;
            default: res = 32'd0;
        endcase
        taken     = live && (s.j || (s.brz && mo.z) || (s.brn && mo.n));
        mo.valid  = live;
        mo.alu    = res;
        mo.rd2    = s.rd2;
        mo.rd     = s.rd;
        mo.pc     = s.pc;
        mo.regw   = live && s.regw;
        mo.wai    = s.wai;
        mo.memw   = live && s.memw;
        mo.memr   = live && s.memr;
        mo.take   = taken;
        if (live && s.regw && !s.memr) begin
            mo.z = (res == 32'd0);
            mo.n = res[31];
        end
        if (taken) begin
            mo.target = s.rd1;
            m_sq      = SLOTS;
        end else if (m_sq > 0 && s.valid) begin
            m_sq = m_sq - 1;
        end
        mo.sq = (m_sq != 0);
    endtask

    task automatic model_reset();
        mo = '{valid: 1'b0, alu: 32'd0, rd2: 32'd0, rd: 6'd0, pc: 32'd0, regw: 1'b0,
               wai: 1'b0, memw: 1'b0, memr: 1'b0, take: 1'b0, target: 32'd0,
               z: 1'b0, n: 1'b0, sq: 1'b0};
        m_sq = 0;
    endtask

    task automatic issue(input stim_t s);
        in_valid  = s.valid;  in_hold  = s.hold;  in_imm  = s.imm;  in_rd1  = s.rd1;
        in_rd2    = s.rd2;    in_PC    = s.pc;    in_rd   = s.rd;   in_brz  = s.brz;
        in_brn    = s.brn;    in_j     = s.j;     in_regw = s.regw; in_wai  = s.wai;
        in_memw   = s.memw;   in_memr  = s.memr;  in_alusrc = s.alusrc;
        in_aluop  = s.aluop;
        model_step(s);
        @(posedge clk);
        exp_q.push_back(mo);
        #1;
    endtask

    task automatic held(input stim_t s, input int cycles);
        stim_t h;
        h      = s;
        h.hold = 1'b1;
        repeat (cycles) issue(h);
        issue(s);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_alu"}, out_alu, 32'd0);
        check({tag, "_pc"}, out_PC, 32'd0);
        check({tag, "_ctl"}, 32'({out_regw, out_wai, out_memw, out_memr, out_take}), 32'd0);
        check({tag, "_target"}, out_target, 32'd0);
        check({tag, "_flags"}, 32'({out_z, out_n, out_squashing}), 32'd0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : monitor
        out_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid", 32'(out_valid), 32'(e.valid));
                check("alu", out_alu, e.alu);
                check("rd2", out_rd2, e.rd2);
                check("rd", 32'(out_rd), 32'(e.rd));
                check("pc", out_PC, e.pc);
                check("regw", 32'(out_regw), 32'(e.regw));
                check("wai", 32'(out_wai), 32'(e.wai));
                check("memw", 32'(out_memw), 32'(e.memw));
                check("memr", 32'(out_memr), 32'(e.memr));
                check("take", 32'(out_take), 32'(e.take));
                check("target", out_target, e.target);
                check("z", 32'(out_z), 32'(e.z));
                check("n", 32'(out_n), 32'(e.n));
                check("squashing", 32'(out_squashing), 32'(e.sq));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        int    h;
        model_reset();
        #3 check_all_zero("por");
        #4 rst_n = 1'b1;

        issue(alu_op(3'b000, 32'd5, 32'd7, 1'b0));
        issue(alu_op(3'b001, 32'd3, 32'd3, 1'b1));
        issue(alu_op(3'b010, 32'd1, 32'd0, 1'b0));

        issue(alu_op(3'b001, 32'd9, 32'd9, 1'b0));
        issue(ctl(1'b1, 1'b0, 1'b0, 32'h40));
        repeat (3) issue(alu_op(3'b000, $urandom, $urandom, 1'b0));

        issue(alu_op(3'b000, 32'd1, 32'd1, 1'b0));
        issue(ctl(1'b0, 1'b1, 1'b0, 32'h80));
        issue(alu_op(3'b000, 32'd2, 32'd2, 1'b0));
        issue(ctl(1'b0, 1'b0, 1'b1, 32'h100));
        repeat (3) issue(alu_op(3'b011, 32'd0, $urandom, 1'b1));

        held(ctl(1'b0, 1'b0, 1'b1, 32'h200), 3);
        held(alu_op(3'b000, 32'd4, 32'd4, 1'b0), 3);
        held(alu_op(3'b000, 32'd6, 32'd6, 1'b0), 2);
        issue(alu_op(3'b100, 32'h8000_0000, 32'd0, 1'b0));

        s       = nop();
        s.memw  = 1'b1;
        s.rd2   = 32'hDEAD_BEEF;
        issue(s);
        s       = alu_op(3'b000, 32'h80, 32'h4, 1'b1);
        s.memr  = 1'b1;
        issue(s);
        s       = alu_op(3'b000, 32'h90, 32'h0, 1'b1);
        s.regw  = 1'b0;
        s.memw  = 1'b1;
        issue(s);

        issue(ctl(1'b0, 1'b0, 1'b1, 32'h300));
        mid_reset();
        issue(alu_op(3'b000, 32'd10, 32'd20, 1'b0));

        for (int i = 0; i < 400; i++) begin
            s        = nop();
            s.valid  = ($urandom_range(0, 3) != 0);
            s.aluop  = 3'($urandom_range(0, 7));
            s.rd1    = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            s.rd2    = ($urandom_range(0, 2) == 0) ? s.rd1 : $urandom;
            s.imm    = ($urandom_range(0, 2) == 0) ? s.rd1 : $urandom;
            s.alusrc = $urandom_range(0, 1) == 1;
            s.rd     = 6'($urandom);
            s.pc     = $urandom;
            s.wai    = $urandom_range(0, 1) == 1;
            s.memw   = $urandom_range(0, 4) == 0;
            s.memr   = $urandom_range(0, 4) == 0;
            s.brz    = $urandom_range(0, 7) == 0;
            s.brn    = $urandom_range(0, 7) == 0;
            s.j      = $urandom_range(0, 11) == 0;
            s.regw   = !(s.brz || s.brn || s.j) && ($urandom_range(0, 3) != 0);
            h        = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            held(s, h);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage3.md
Name: stage3

Overview:
- Execute stage of the 5-stage pipeline. Sits directly downstream of the decode stage and consumes its ID/EX outputs (imm, rd, rd1, rd2, PC, control bits).
- Performs the ALU operation, maintains the Z/N condition flags, and resolves J/BRZ/BRN.
- Squashes wrong-path instructions after a taken control transfer.
- Registers its results into an internal EX/MEM buffer that feeds the memory stage.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 6, register-index width.
- SQUASH_SLOTS, 2, number of valid inputs discarded after a taken branch/jump (range 0..3).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ID/EX slot holds a real instruction
- in_imm  input  WIDTH  sign-extended immediate
- in_rd  input  RADDR  destination register index
- in_rd1  input  WIDTH  operand A / branch-jump target
- in_rd2  input  WIDTH  operand B / store data
- in_PC  input  WIDTH  instruction PC (passed through)
- in_brz, in_brn, in_j, in_regw, in_wai, in_memw, in_memr, in_alusrc  input  1 each  control bits from decode
- in_aluop  input  3  ALU select
- in_hold  input  1  memory stage not ready; freeze this stage
- out_valid  output  1  EX/MEM slot valid
- out_alu  output  WIDTH  ALU result / memory address
- out_rd2  output  WIDTH  store data
- out_rd  output  RADDR  destination index
- out_PC  output  WIDTH  passed-through PC
- out_regw, out_wai, out_memw, out_memr  output  1 each  registered control
- out_take  output  1  one-cycle pulse: redirect fetch
- out_target  output  WIDTH  redirect address, valid when out_take=1
- out_z, out_n  output  1  current flag state
- out_squashing  output  1  squash counter nonzero

Behaviour:
- Reset (async, rst_n=0): all outputs 0; flags Z=N=0; squash counter 0. Release is synchronous to the next clk edge.
- Operand B = in_alusrc ? in_imm : in_rd2.
- ALU, combinational, mod 2^WIDTH:
  - 000: A+B
  - 001: A−B
  - 010: −A (two's complement)
  - 011: B
  - 100: A
  - 101–111: 0
- eff_valid = in_valid & (squash counter == 0).
- Every edge with in_hold=0:
  - EX/MEM register loads the ALU result, in_rd2, in_rd, in_PC and the control bits.
  - out_valid <= eff_valid.
  - When eff_valid=0, out_regw/out_memw/out_memr <= 0 (bubble); data fields are don't-care but must still load.
- Latency: 1 cycle from ID/EX input to EX/MEM output.
- Flags:
  - Update when eff_valid & in_regw & ~in_memr & in_hold=0.
  - Z <= (result==0); N <= result[WIDTH-1].
  - Otherwise hold.
- Branch resolution uses flags before this instruction's own update: take = eff_valid & (in_j | in_brz&Z | in_brn&N).
- When take & in_hold=0:
  - out_take <= 1 and out_target <= in_rd1 for exactly one cycle.
  - Squash counter <= SQUASH_SLOTS.
- Otherwise out_take <= 0; out_target holds its last value.
- Squash counter:
  - Decrements by 1 on each edge with in_hold=0 and in_valid=1 while nonzero.
  - Never underflows.
  - Squashed inputs produce bubbles, no flag update and no take.
- Branch instructions still pass through as valid with out_regw as supplied (decode drives it 0).
- Hold (in_hold=1):
  - EX/MEM register, flags and squash counter freeze.
  - out_take <= 0, so a pending redirect is issued only once, on the non-hold edge.
  - Upstream must present the same ID/EX contents until hold drops.
- Simultaneous events:
  - take while counter nonzero is impossible: a squashed input cannot take.
  - Reset mid-squash clears the counter immediately.
  - Reset mid-hold clears everything regardless of in_hold.
- SQUASH_SLOTS=0: no squashing; take still pulses.

Test Plan:
- Reset/ALU:
  - Assert rst_n=0 mid-stream → all outputs 0 asynchronously.
  - Release, then present aluop=000, rd1=5, rd2=7, alusrc=0, regw=1, valid=1 → next cycle out_alu=12, out_valid=1, Z=0, N=0.
- Immediate and flags: aluop=001, rd1=3, imm=3, alusrc=1, regw=1 → out_alu=0, Z=1. Follow with aluop=010, rd1=1 → out_alu=0xFFFFFFFF, N=1, Z=0.
- BRZ taken:
  - Set Z=1, then present brz=1, rd1=0x40 → out_take=1 for one cycle, out_target=0x40.
  - Next two valid inputs (add, regw=1) emerge with out_valid=0, out_regw=0 and flags unchanged.
  - Third input executes normally.
- BRN not taken: N=0, brn=1 → out_take stays 0 and there is no squash. J with rd1=0x100 → take regardless of flags.
- Hold:
  - Raise in_hold for 3 cycles while a J and a following add are presented → outputs and flags frozen, no out_take during hold.
  - Single out_take on release; squash counter unchanged during hold.
- Bubble/memory: valid=0 with memw=1 → out_memw=0. Valid LD (memr=1, regw=1, aluop=000) → flags unchanged, out_alu equals the address.
